// File: rtl/div_ctrl.sv
// div_ctrl: sequencer for the shared radix-2 restoring divider behind DIV/DIVU/REM/REMU.
// Optional build macro DIV_EARLY_OUT_EN: finish at accept when |dividend| < |divisor|.
module div_ctrl #(
   parameter int XLEN = 32
) (
   input  logic            clock,
   input  logic            reset,
   input  logic            enable,
   input  logic [3:0]      div_op,
   input  logic [XLEN-1:0] rdata1,
   input  logic [XLEN-1:0] rdata2,
   input  logic            clear,
   output logic            busy,
   output logic            ready,
   output logic [XLEN-1:0] result
);
   localparam int CNT_W = $clog2(XLEN) + 1;
   localparam logic [XLEN-1:0] ONE     = {{(XLEN-1){1'b0}}, 1'b1};
   localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

   typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;
   state_t state, state_nxt;

   logic [XLEN-1:0]  dvd, dvs, rem_acc, quo;
   logic [CNT_W-1:0] cnt;
   logic             want_rem, bypass, neg_q, neg_r;

   function automatic logic [XLEN-1:0] negate(input logic [XLEN-1:0] v, input logic en);
      return en ? (~v + ONE) : v;
   endfunction

   function automatic logic [XLEN-1:0] magnitude(input logic signed [XLEN-1:0] v,
                                                 input logic is_signed);
      return (is_signed && (v < 0)) ? (~v + ONE) : v;
   endfunction

   // Op decode: anything that is not exactly one-hot falls through to divu.
   logic op_div, op_rem, op_remu, op_signed, op_want_rem;
   assign op_div      = (div_op == 4'b1000);
   assign op_rem      = (div_op == 4'b0010);
   assign op_remu     = (div_op == 4'b0001);
   assign op_signed   = op_div | op_rem;
   assign op_want_rem = op_rem | op_remu;

   logic signed [XLEN-1:0] dividend_s, divisor_s;
   logic [XLEN-1:0]        abs_a, abs_b;
   logic                   sign_a, sign_b, div_zero, ovf, early;
   assign dividend_s = rdata1;
   assign divisor_s  = rdata2;
   assign abs_a      = magnitude(dividend_s, op_signed);
   assign abs_b      = magnitude(divisor_s, op_signed);
   assign sign_a     = op_signed & (dividend_s < 0);
   assign sign_b     = op_signed & (divisor_s < 0);
   assign div_zero   = (rdata2 == '0);
   assign ovf        = op_signed && (rdata1 == MIN_NEG) && (rdata2 == '1);
`ifdef DIV_EARLY_OUT_EN
   assign early      = (abs_a < abs_b);
`else
   assign early      = 1'b0;
`endif

   // One restoring step: shift in the next dividend bit, keep the trial difference if non-negative.
   logic [XLEN-1:0] rem_sh;
   logic [XLEN:0]   trial;
   logic [XLEN-1:0] fixed;
   assign rem_sh = {rem_acc[XLEN-2:0], dvd[XLEN-1]};
   assign trial  = {1'b0, rem_sh} - {1'b0, dvs};
   assign fixed  = want_rem ? negate(rem_acc, neg_r & ~bypass)
                            : negate(quo, neg_q & ~bypass);

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      busy      = (state != IDLE);
      case (state)
         IDLE: if (enable) state_nxt = (div_zero || ovf || early) ? FIX : RUN;
         RUN:  if (cnt == CNT_W'(1)) state_nxt = FIX;
         FIX:  state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
      if (clear) state_nxt = IDLE;
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         dvd      <= '0;
         dvs      <= '0;
         rem_acc  <= '0;
         quo      <= '0;
         cnt      <= '0;
         want_rem <= 1'b0;
         bypass   <= 1'b0;
         neg_q    <= 1'b0;
         neg_r    <= 1'b0;
         ready    <= 1'b0;
         result   <= '0;
      end else begin
         ready <= 1'b0;
         if (!clear) begin
            case (state)
               IDLE: if (enable) begin
                  want_rem <= op_want_rem;
                  bypass   <= div_zero | ovf;
                  neg_q    <= op_div & (sign_a ^ sign_b);
                  neg_r    <= op_rem & sign_a;
                  dvd      <= abs_a;
                  dvs      <= abs_b;
                  cnt      <= CNT_W'(XLEN);
                  quo      <= '0;
                  rem_acc  <= '0;
                  if (div_zero) begin
                     quo     <= '1;
                     rem_acc <= rdata1;
                  end else if (ovf) begin
                     quo     <= rdata1;
                  end else if (early) begin
                     rem_acc <= abs_a;
                  end
               end
               RUN: begin
                  dvd     <= {dvd[XLEN-2:0], 1'b0};
                  rem_acc <= trial[XLEN] ? rem_sh : trial[XLEN-1:0];
                  quo     <= {quo[XLEN-2:0], ~trial[XLEN]};
                  cnt     <= cnt - CNT_W'(1);
               end
               FIX: begin
                  result <= fixed;
                  ready  <= 1'b1;
               end
               default: ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_div_ctrl.sv
// tb_div_ctrl: directed + randomized bench for div_ctrl against an arithmetic reference model.
module tb_div_ctrl;
   localparam int XLEN = 32;
   localparam logic [3:0]  OP_DIV  = 4'b1000;
   localparam logic [3:0]  OP_DIVU = 4'b0100;
   localparam logic [3:0]  OP_REM  = 4'b0010;
   localparam logic [3:0]  OP_REMU = 4'b0001;
   localparam logic [31:0] MIN     = 32'h8000_0000;

   logic        clock  = 1'b0;
   logic        reset  = 1'b0;
   logic        enable = 1'b0;
   logic        clear  = 1'b0;
   logic [3:0]  div_op = 4'b0000;
   logic [31:0] rdata1 = '0;
   logic [31:0] rdata2 = '0;
   logic        busy, ready;
   logic [31:0] result;

   int checks = 0;
   int errors = 0;

   div_ctrl #(.XLEN(XLEN)) dut (
      .clock  (clock),
      .reset  (reset),
      .enable (enable),
      .div_op (div_op),
      .rdata1 (rdata1),
      .rdata2 (rdata2),
      .clear  (clear),
      .busy   (busy),
      .ready  (ready),
      .result (result)
   );

   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Reference: RISC-V M-extension results computed with 64-bit integer arithmetic.
   function automatic logic [31:0] model(input logic [3:0] op, input logic [31:0] a,
                                         input logic [31:0] b);
      longint sa, sb, ua, ub;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      ua = longint'(a);
      ub = longint'(b);
      case (op)
         OP_DIV:  return (b == 0) ? 32'hFFFF_FFFF : 32'(sa / sb);
         OP_REM:  return (b == 0) ? a : 32'(sa % sb);
         OP_REMU: return (b == 0) ? a : 32'(ua % ub);
         default: return (b == 0) ? 32'hFFFF_FFFF : 32'(ua / ub);
      endcase
   endfunction

   function automatic int exp_latency(input logic [3:0] op, input logic [31:0] a,
                                      input logic [31:0] b);
      bit sgn;
`ifdef DIV_EARLY_OUT_EN
      longint ma, mb;
`endif
      sgn = (op == OP_DIV) || (op == OP_REM);
      if (b == 0) return 1;
      if (sgn && a == MIN && b == 32'hFFFF_FFFF) return 1;
`ifdef DIV_EARLY_OUT_EN
      ma = sgn ? longint'($signed(a)) : longint'(a);
      mb = sgn ? longint'($signed(b)) : longint'(b);
      if (ma < 0) ma = -ma;
      if (mb < 0) mb = -mb;
      if (ma < mb) return 1;
`endif
      return XLEN + 1;
   endfunction

   // Entered at the negedge right after the accepting edge; junk enables exercise the busy lockout.
   task automatic wait_ready(input bit noise, output int lat);
      lat = 0;
      while (ready !== 1'b1 && lat < 80) begin
         if (noise) begin
            enable = 1'($urandom_range(0, 1));
            div_op = 4'($urandom);
            rdata1 = $urandom;
            rdata2 = $urandom;
         end
         @(negedge clock);
         lat++;
      end
      enable = 1'b0;
   endtask

   task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input string tag);
      int lat;
      logic [31:0] exp_r;
      exp_r = model(op, a, b);
      @(negedge clock);
      enable = 1'b1; div_op = op; rdata1 = a; rdata2 = b;
      @(negedge clock);
      enable = 1'b0; rdata1 = $urandom; rdata2 = $urandom;
      chk({tag, " busy"}, 32'(busy), 32'd1);
      wait_ready(1'b1, lat);
      chk({tag, " latency"}, 32'(lat), 32'(exp_latency(op, a, b)));
      chk({tag, " result"}, result, exp_r);
      chk({tag, " busy@ready"}, 32'(busy), 32'd0);
      @(negedge clock);
      chk({tag, " ready pulse"}, 32'(ready), 32'd0);
      chk({tag, " hold"}, result, exp_r);
   endtask

   initial begin
      int lat, seen;
      logic [31:0] prev, a, b;
      logic [3:0]  op;

      // Reset state
      #2;
      chk("reset busy", 32'(busy), 32'd0);
      chk("reset ready", 32'(ready), 32'd0);
      chk("reset result", result, 32'd0);
      @(negedge clock);
      reset = 1'b1;
      @(negedge clock);
      chk("idle busy", 32'(busy), 32'd0);

      // Directed corner and example cases
      run_op(OP_DIVU, 32'd100, 32'd7, "divu 100/7");
      run_op(OP_REMU, 32'd100, 32'd7, "remu 100/7");
      run_op(OP_DIV, -32'sd20, 32'd3, "div -20/3");
      run_op(OP_REM, -32'sd20, 32'd3, "rem -20/3");
      run_op(OP_DIV, 32'd5, 32'd0, "div 5/0");
      run_op(OP_REM, 32'd5, 32'd0, "rem 5/0");
      run_op(OP_DIV, MIN, 32'hFFFF_FFFF, "div ovf");
      run_op(OP_REM, MIN, 32'hFFFF_FFFF, "rem ovf");
      run_op(OP_DIVU, 32'd3, 32'd10, "divu 3/10");
      run_op(OP_REMU, 32'd3, 32'd10, "remu 3/10");
      run_op(OP_REM, -32'sd3, 32'd10, "rem -3/10");
      run_op(OP_DIVU, 32'hFFFF_FFFF, 32'hFFFF_FFFE, "divu big");
      run_op(OP_DIVU, 32'hFFFF_FFFF, 32'd1, "divu by 1");
      run_op(4'b1100, 32'd1000, 32'd9, "illegal op");

      // clear during RUN with enable asserted in the same cycle
      prev = result;
      @(negedge clock);
      enable = 1'b1; div_op = OP_DIVU; rdata1 = 32'd1000; rdata2 = 32'd3;
      @(negedge clock);
      enable = 1'b0;
      repeat (9) @(negedge clock);
      clear = 1'b1; enable = 1'b1; rdata1 = 32'd77; rdata2 = 32'd5;
      @(negedge clock);
      clear = 1'b0; enable = 1'b0;
      chk("clear busy", 32'(busy), 32'd0);
      chk("clear result", result, prev);
      seen = 0;
      repeat (40) begin
         @(negedge clock);
         if (ready === 1'b1) seen++;
      end
      chk("clear no ready", 32'(seen), 32'd0);
      chk("clear result held", result, prev);

      // clear in the FIX cycle of a short op
      @(negedge clock);
      enable = 1'b1; div_op = OP_DIV; rdata1 = 32'd5; rdata2 = 32'd0;
      @(negedge clock);
      enable = 1'b0; clear = 1'b1;
      @(negedge clock);
      clear = 1'b0;
      chk("clear fix ready", 32'(ready), 32'd0);
      chk("clear fix busy", 32'(busy), 32'd0);
      chk("clear fix result", result, prev);

      // Back-to-back: new op accepted in the ready cycle
      @(negedge clock);
      enable = 1'b1; div_op = OP_DIVU; rdata1 = 32'd100; rdata2 = 32'd7;
      @(negedge clock);
      enable = 1'b0;
      wait_ready(1'b1, lat);
      chk("b2b first latency", 32'(lat), 32'd33);
      chk("b2b first result", result, 32'd14);
      enable = 1'b1; div_op = OP_REMU; rdata1 = 32'd100; rdata2 = 32'd7;
      @(negedge clock);
      enable = 1'b0;
      chk("b2b second busy", 32'(busy), 32'd1);
      wait_ready(1'b1, lat);
      chk("b2b second latency", 32'(lat), 32'd33);
      chk("b2b second result", result, 32'd2);

      // Randomized ops with biased operand classes
      for (int i = 0; i < 30; i++) begin
         case ($urandom_range(0, 4))
            0: op = OP_DIV;
            1: op = OP_DIVU;
            2: op = OP_REM;
            3: op = OP_REMU;
            default: op = 4'b0000;
         endcase
         a = $urandom;
         b = $urandom;
         case ($urandom_range(0, 5))
            0: b = 32'd0;
            1: begin a = MIN; b = 32'hFFFF_FFFF; end
            2: b = 32'($urandom_range(1, 15));
            3: a = 32'($urandom_range(0, 255));
            default: ;
         endcase
         run_op(op, a, b, $sformatf("rand%0d", i));
      end

      // Asynchronous reset mid-operation
      @(negedge clock);
      enable = 1'b1; div_op = OP_DIVU; rdata1 = 32'd1000; rdata2 = 32'd3;
      @(negedge clock);
      enable = 1'b0;
      repeat (5) @(negedge clock);
      #2 reset = 1'b0;
      #1;
      chk("async rst busy", 32'(busy), 32'd0);
      chk("async rst ready", 32'(ready), 32'd0);
      chk("async rst result", result, 32'd0);
      @(negedge clock);
      reset = 1'b1;
      seen = 0;
      repeat (40) begin
         @(negedge clock);
         if (ready === 1'b1) seen++;
      end
      chk("async rst no ready", 32'(seen), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
